keypad_scanner: RTL and testbench

- Scans a 4x4 passive key matrix by driving one column low at a time and sampling the four pulled-up row lines.
- Debounces presses and releases over whole sweeps, then encodes the pressed key into a 4-bit code.
- Holds the code in a one-entry read buffer with a valid/read handshake.
- Acts as the input-side counterpart of the scanned LED-matrix driver: it replaces single-button polling for the game logic.

---
 rtl/keypad_scanner.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_scanner
//  Function : 4x4 key-matrix column scanner with sweep-level debounce and a
//             one-entry read buffer. Define KEYPAD_REPEAT_EN for auto-repeat.
//  Revision : 1.0 - initial release
// ============================================================================
module keypad_scanner #(
    parameter int SCAN_DIV       = 5000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SCANS   = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_row,
    output logic [3:0] key_col,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_rd,
    output logic       key_held,
    output logic       overrun
);

    localparam int c_DWELL_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_CNT_W   = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [c_DWELL_W-1:0] c_DWELL_LAST = c_DWELL_W'(SCAN_DIV - 1);
    localparam logic [c_CNT_W-1:0]   c_DEB_MAX    = c_CNT_W'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2
    } state_t;

    generate
        if (SCAN_DIV < 2) begin : g_chk_scan_div
            $error("keypad_scanner: SCAN_DIV must be >= 2");
        end
        if (DEBOUNCE_SCANS < 1) begin : g_chk_debounce
            $error("keypad_scanner: DEBOUNCE_SCANS must be >= 1");
        end
        if (REPEAT_SCANS < 1) begin : g_chk_repeat
            $error("keypad_scanner: REPEAT_SCANS must be >= 1");
        end
    endgenerate

    // Synchronizer resets to the released (all-high) level so no phantom press
    // is seen in the first sweep after reset.
    logic [3:0] r_row_meta;
    logic [3:0] r_row_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_row_meta <= 4'hF;
            r_row_sync <= 4'hF;
        end else begin
            r_row_meta <= key_row;
            r_row_sync <= r_row_meta;
        end
    end

    logic [c_DWELL_W-1:0] r_dwell;
    logic [1:0]           r_col;
    logic                 w_sample;
    logic                 w_eval;

    assign w_sample = (r_dwell == c_DWELL_LAST);
    assign w_eval   = w_sample && (r_col == 2'd3);
    assign key_col  = ~(4'b0001 << r_col);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dwell <= '0;
            r_col   <= 2'd0;
        end else if (w_sample) begin
            r_dwell <= '0;
            r_col   <= r_col + 2'd1;
        end else begin
            r_dwell <= r_dwell + c_DWELL_W'(1);
        end
    end

    // Per-sweep hit accumulation: hits saturates at 2, meaning "two or more".
    logic [1:0] r_acc_hits;
    logic [3:0] r_acc_code;
    logic [3:0] w_col_low;
    logic [2:0] w_col_ones;
    logic [1:0] w_col_row;
    logic [2:0] w_sum;
    logic [1:0] w_hits;
    logic [3:0] w_code;
    logic       w_none;
    logic       w_single;

    always_comb begin
        w_col_low  = ~r_row_sync;
        w_col_ones = 3'd0;
        w_col_row  = 2'd0;
        for (int r = 0; r < 4; r++) begin
            if (w_col_low[r]) begin
                w_col_ones = w_col_ones + 3'd1;
                w_col_row  = 2'(r);
            end
        end
        w_sum    = {1'b0, r_acc_hits} + w_col_ones;
        w_hits   = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
        w_code   = (r_acc_hits == 2'd1) ? r_acc_code : {w_col_row, r_col};
        w_none   = (w_hits == 2'd0);
        w_single = (w_hits == 2'd1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc_hits <= 2'd0;
            r_acc_code <= 4'd0;
        end else if (w_eval) begin
            r_acc_hits <= 2'd0;
            r_acc_code <= 4'd0;
        end else if (w_sample) begin
            r_acc_hits <= w_hits;
            r_acc_code <= w_code;
        end
    end

    state_t             r_state;
    state_t             w_state_nxt;
    logic [3:0]         r_cand;
    logic [3:0]         w_cand_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [c_CNT_W-1:0] w_cnt_inc;
    logic [c_CNT_W-1:0] r_rel_cnt;
    logic [c_CNT_W-1:0] w_rel_nxt;
    logic [c_CNT_W-1:0] w_rel_inc;
    logic               w_load;
    logic [3:0]         w_load_code;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_SCAN;
            r_cand    <= 4'd0;
            r_cnt     <= '0;
            r_rel_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cand    <= w_cand_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rel_cnt <= w_rel_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cand_nxt  = r_cand;
        w_cnt_nxt   = r_cnt;
        w_rel_nxt   = r_rel_cnt;
        w_load      = 1'b0;
        w_load_code = r_cand;
        w_cnt_inc   = (r_cnt == c_DEB_MAX) ? r_cnt : r_cnt + c_CNT_W'(1);
        w_rel_inc   = (r_rel_cnt == c_DEB_MAX) ? r_rel_cnt : r_rel_cnt + c_CNT_W'(1);
        if (w_eval) begin
            case (r_state)
                ST_SCAN: begin
                    if (w_single) begin
                        w_cand_nxt = w_code;
                        if (DEBOUNCE_SCANS == 1) begin
                            w_load      = 1'b1;
                            w_load_code = w_code;
                            w_rel_nxt   = '0;
                            w_state_nxt = ST_PRESSED;
                        end else begin
                            w_cnt_nxt   = c_CNT_W'(1);
                            w_state_nxt = ST_DEBOUNCE;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (w_single && (w_code == r_cand)) begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == c_DEB_MAX) begin
                            w_load      = 1'b1;
                            w_rel_nxt   = '0;
                            w_cnt_nxt   = '0;
                            w_state_nxt = ST_PRESSED;
                        end
                    end else if (w_single) begin
                        w_cand_nxt = w_code;
                        w_cnt_nxt  = c_CNT_W'(1);
                    end else begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_SCAN;
                    end
                end
                ST_PRESSED: begin
                    if (w_none) begin
                        w_rel_nxt = w_rel_inc;
                        if (w_rel_inc == c_DEB_MAX) begin
                            w_rel_nxt   = '0;
                            w_cnt_nxt   = '0;
                            w_state_nxt = ST_SCAN;
                        end
                    end else begin
                        w_rel_nxt = '0;
                    end
                end
                default: begin
                    w_state_nxt = ST_SCAN;
                end
            endcase
        end
    end

    logic w_rep_load;

`ifdef KEYPAD_REPEAT_EN
    localparam int c_REP_W = $clog2(REPEAT_SCANS + 1);
    localparam logic [c_REP_W-1:0] c_REP_MAX = c_REP_W'(REPEAT_SCANS);

    logic [c_REP_W-1:0] r_rep_cnt;
    logic [c_REP_W-1:0] w_rep_nxt;
    logic [c_REP_W-1:0] w_rep_inc;

    // r_cand holds the accepted code for the whole time the key is held.
    always_comb begin
        w_rep_nxt  = r_rep_cnt;
        w_rep_load = 1'b0;
        w_rep_inc  = (r_rep_cnt == c_REP_MAX) ? r_rep_cnt : r_rep_cnt + c_REP_W'(1);
        if (w_load) begin
            w_rep_nxt = '0;
        end else if (w_eval && (r_state == ST_PRESSED)) begin
            if (w_single && (w_code == r_cand)) begin
                if (w_rep_inc == c_REP_MAX) begin
                    w_rep_load = 1'b1;
                    w_rep_nxt  = '0;
                end else begin
                    w_rep_nxt = w_rep_inc;
                end
            end else begin
                w_rep_nxt = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rep_cnt <= '0;
        end else begin
            r_rep_cnt <= w_rep_nxt;
        end
    end
`else
    assign w_rep_load = 1'b0;
`endif

    logic       w_buf_load;
    logic [3:0] w_buf_code;
    logic [3:0] r_key_code;
    logic       r_key_valid;
    logic       r_overrun;

    assign w_buf_load = w_load | w_rep_load;
    assign w_buf_code = w_load ? w_load_code : r_cand;

    // A load beats a same-cycle read; overrun only when the old code is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_code  <= 4'd0;
            r_key_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else if (w_buf_load) begin
            r_key_code  <= w_buf_code;
            r_key_valid <= 1'b1;
            if (r_key_valid && !key_rd) begin
                r_overrun <= 1'b1;
            end
        end else if (key_rd) begin
            r_key_valid <= 1'b0;
        end
    end

    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign overrun   = r_overrun;
    assign key_held  = (r_state == ST_PRESSED);

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_keypad_scanner
//  Function : Directed + random key-matrix stimulus for keypad_scanner, checked
//             against a sweep-level reference model. Honours KEYPAD_REPEAT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

    localparam int SD    = 4;
    localparam int DS    = 2;
    localparam int RS    = 3;
    localparam int SWEEP = 4 * SD;
`ifdef KEYPAD_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_rd = 1'b0;
    logic [3:0]  key_row;
    logic [3:0]  key_col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic        overrun;
    logic [15:0] pressed = 16'h0000;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit         m_valid, m_over, m_held;
    logic [3:0] m_code, run_code, held_code;
    int         run_len, none_run, rep;

    always #5 clk = ~clk;

    keypad_scanner #(
        .SCAN_DIV       (SD),
        .DEBOUNCE_SCANS (DS),
        .REPEAT_SCANS   (RS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_row   (key_row),
        .key_col   (key_col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_rd    (key_rd),
        .key_held  (key_held),
        .overrun   (overrun)
    );

    // Passive switch matrix: key r*4+c shorts row r to column c.
    always_comb begin
        key_row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !key_col[c]) key_row[r] = 1'b0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_over = 0; m_held = 0; m_code = 4'd0;
        run_code = 4'd0; held_code = 4'd0; run_len = 0; none_run = 0; rep = 0;
    endtask

    task automatic model_sweep(input logic [15:0] mask, input bit rd_at_eval);
        int         n;
        int         idx;
        bit         load;
        logic [3:0] lc;
        n = $countones(mask);
        idx = 0;
        for (int i = 0; i < 16; i++) if (mask[i]) idx = i;
        load = 0;
        lc = 4'd0;
        if (!m_held) begin
            if (n == 1) begin
                if (run_len > 0 && 4'(idx) == run_code) run_len++;
                else begin run_len = 1; run_code = 4'(idx); end
                if (run_len >= DS) begin
                    load = 1; lc = run_code; held_code = run_code;
                    m_held = 1; none_run = 0; rep = 0; run_len = 0;
                end
            end else begin
                run_len = 0;
            end
        end else if (n == 0) begin
            none_run++;
            rep = 0;
            if (none_run >= DS) begin m_held = 0; none_run = 0; run_len = 0; end
        end else begin
            none_run = 0;
            if (REP_EN && n == 1 && 4'(idx) == held_code) begin
                rep++;
                if (rep >= RS) begin load = 1; lc = held_code; rep = 0; end
            end else begin
                rep = 0;
            end
        end
        if (load) begin
            if (m_valid && !rd_at_eval) m_over = 1;
            m_valid = 1;
            m_code = lc;
        end else if (rd_at_eval) begin
            m_valid = 0;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".key_valid"}, 32'(key_valid), 32'(m_valid));
        check({tag, ".key_code"},  32'(key_code),  32'(m_code));
        check({tag, ".key_held"},  32'(key_held),  32'(m_held));
        check({tag, ".overrun"},   32'(overrun),   32'(m_over));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".key_col"},   32'(key_col),   32'h0000000E);
        check({tag, ".key_valid"}, 32'(key_valid), 32'd0);
        check({tag, ".key_code"},  32'(key_code),  32'd0);
        check({tag, ".key_held"},  32'(key_held),  32'd0);
        check({tag, ".overrun"},   32'(overrun),   32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        check_reset_values("reset");
        rst = 1'b0;
        model_reset();
    endtask

    // One full sweep with a stable key set; optional read strobe at offset rd_off.
    task automatic run_sweep(input string tag, input logic [15:0] mask, input int rd_off);
        logic [3:0] exp_col;
        pressed = mask;
        for (int j = 0; j < SWEEP; j++) begin
            exp_col = ~(4'b0001 << (j / SD));
            check({tag, ".key_col"}, 32'(key_col), 32'(exp_col));
            key_rd = (j == rd_off);
            tick();
            key_rd = 1'b0;
            if (j == rd_off && j < SWEEP - 1) begin
                m_valid = 0;
                check({tag, ".rd_clear"}, 32'(key_valid), 32'd0);
            end
        end
        model_sweep(mask, rd_off == SWEEP - 1);
        check_outputs(tag);
    endtask

    // Partial sweep, then reset asserted for one cycle at offset off.
    task automatic sweep_then_reset(input logic [15:0] mask, input int off);
        pressed = mask;
        for (int j = 0; j < off; j++) tick();
        do_reset();
    endtask

    initial begin
        logic [15:0] mask;
        int          held_key;
        int          sel;
        int          a, b, rd;

        model_reset();
        repeat (3) tick();
        do_reset();

        // Idle sweep: column walk and quiet outputs
        run_sweep("idle", 16'h0000, -1);
        run_sweep("idle2", 16'h0000, -1);

        // Single press of key 6 (row1, col2), read, release
        repeat (3) run_sweep("press6", 16'h0040, -1);
        run_sweep("read6", 16'h0040, 3);
        repeat (2) run_sweep("release6", 16'h0000, -1);

        // Bounce: alternating sweeps never accumulate
        repeat (2) begin
            run_sweep("bounce_on", 16'h0040, -1);
            run_sweep("bounce_off", 16'h0000, -1);
        end

        // Ghosting: keys 0 and 5 together, then only key 0
        repeat (3) run_sweep("multi", 16'h0021, -1);
        repeat (2) run_sweep("ghost_rel", 16'h0001, -1);
        run_sweep("read0", 16'h0001, 7);
        repeat (2) run_sweep("release0", 16'h0000, -1);

        // Overrun: key 3 unread, then key 9
        repeat (2) run_sweep("press3", 16'h0008, -1);
        repeat (2) run_sweep("release3", 16'h0000, -1);
        repeat (2) run_sweep("press9", 16'h0200, -1);
        repeat (2) run_sweep("release9", 16'h0000, -1);

        // Load and read in the same cycle
        do_reset();
        repeat (2) run_sweep("press3b", 16'h0008, -1);
        repeat (2) run_sweep("release3b", 16'h0000, -1);
        run_sweep("press10", 16'h0400, -1);
        run_sweep("load_rd", 16'h0400, SWEEP - 1);
        repeat (2) run_sweep("release10", 16'h0000, -1);
        run_sweep("read10", 16'h0000, 2);

        // Long hold of key 12 (auto-repeat when enabled)
        repeat (10) run_sweep("hold12", 16'h1000, -1);
        run_sweep("read12", 16'h1000, 9);
        repeat (2) run_sweep("release12", 16'h0000, -1);

        // Reset mid-debounce and on the would-be load edge
        do_reset();
        run_sweep("deb7", 16'h0080, -1);
        sweep_then_reset(16'h0080, SWEEP - 1);
        run_sweep("deb7b", 16'h0080, -1);
        sweep_then_reset(16'h0080, 8);
        repeat (2) run_sweep("press7", 16'h0080, -1);
        repeat (2) run_sweep("release7", 16'h0000, -1);

        // Randomized key activity
        held_key = int'($urandom_range(0, 15));
        for (int s = 0; s < 60; s++) begin
            sel = int'($urandom_range(0, 9));
            mask = 16'h0000;
            if (sel >= 3 && sel <= 6) begin
                mask[held_key] = 1'b1;
            end else if (sel == 7) begin
                held_key = int'($urandom_range(0, 15));
                mask[held_key] = 1'b1;
            end else if (sel == 8) begin
                a = int'($urandom_range(0, 15));
                b = (a + int'($urandom_range(1, 15))) % 16;
                mask[a] = 1'b1;
                mask[b] = 1'b1;
            end else if (sel == 9) begin
                mask = 16'($urandom);
            end
            rd = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, SWEEP - 1)) : -1;
            run_sweep("random", mask, rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
